// File: rtl/sd_pkg.sv
// Shared constants and state encoding for the SPI-mode SD card responder.
package sd_pkg;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD17 = 6'd17;
  localparam logic [5:0] CMD24 = 6'd24;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;
  localparam logic [5:0] CMD58 = 6'd58;

  localparam logic [7:0] R1_IDLE       = 8'h01;
  localparam logic [7:0] R1_ILLEGAL    = 8'h04;
  localparam logic [7:0] START_TOKEN   = 8'hFE;
  localparam logic [7:0] DATA_ACCEPTED = 8'h05;
  localparam logic [7:0] FILL_BYTE     = 8'hFF;
  localparam logic [7:0] BUSY_BYTE     = 8'h00;
  localparam logic [31:0] OCR_VALUE    = 32'hC0FF8000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_NCR,
    S_RESP,
    S_RD_TOK,
    S_RD_DATA,
    S_RD_CRC,
    S_WR_TOK,
    S_WR_DATA,
    S_WR_CRC,
    S_WR_RESP,
    S_WR_BUSY
  } sd_state_e;

endpackage

// File: rtl/sd_resp_mem.sv
// Single-port byte RAM backing the responder's block store; sync write, registered read.
module sd_resp_mem #(
  parameter int unsigned DEPTH = 2048
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [7:0]               wdata_i,
  output logic [7:0]               rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sd_spi_responder.sv
// Card side of an SD SPI link: command decode, R1/R3/R7 responses, single-block read/write.
module sd_spi_responder
  import sd_pkg::*;
#(
  parameter int unsigned NCR_BYTES     = 1,
  parameter int unsigned INIT_BUSY_CNT = 2,
  parameter int unsigned MEM_BLOCKS    = 4,
  parameter int unsigned TOKEN_DELAY   = 2,
  parameter int unsigned BUSY_BYTES    = 4
) (
  input  logic        SD_clk,
  input  logic        rst_n,
  input  logic        SD_cs,
  input  logic        SD_datain,
  output logic        SD_dataout,
  output logic        init_done,
  output logic        cmd_valid,
  output logic [5:0]  cmd_idx,
  output logic [31:0] cmd_arg,
  output logic        rd_done,
  output logic        wr_done
);

  localparam int unsigned BW = $clog2(MEM_BLOCKS);
  localparam int unsigned AW = BW + 9;

  sd_state_e   state_q, state_d;
  sd_state_e   post_q, post_d;
  logic [2:0]  bit_cnt_q;
  logic [6:0]  rx_sr_q;
  logic [7:0]  rx_byte;
  logic        byte_done;
  logic [7:0]  tx_sr_q, tx_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        rd_done_q, rd_done_d;
  logic        wr_done_q, wr_done_d;
  logic        dout_q;

  logic        init_done_q, init_done_d;
  logic [7:0]  acmd_cnt_q, acmd_cnt_d;
  logic        app_q, app_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] arg_q, arg_d;
  logic [7:0]  r1_q, r1_d;
  logic [31:0] resp_q, resp_d;
  logic        long_q, long_d;
  logic [BW-1:0] blk_q, blk_d;
  logic        idle;
  logic [7:0]  illegal;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [8:0]    rd_off;
  logic [7:0]    mem_rdata;

  assign rx_byte   = {rx_sr_q, SD_datain};
  assign byte_done = (bit_cnt_q == 3'd7) && !SD_cs;

  // Framing and FSM state: chip-select release aborts to idle without waiting for a byte boundary.
  always_ff @(posedge SD_clk or negedge rst_n or posedge SD_cs) begin
    if (!rst_n || SD_cs) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= FILL_BYTE;
      cnt_q       <= '0;
      cmd_valid_q <= 1'b0;
      rd_done_q   <= 1'b0;
      wr_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_q + 3'd1;
      rx_sr_q     <= rx_byte[6:0];
      tx_sr_q     <= tx_d;
      cnt_q       <= cnt_d;
      cmd_valid_q <= cmd_valid_d;
      rd_done_q   <= rd_done_d;
      wr_done_q   <= wr_done_d;
    end
  end

  always_ff @(posedge SD_clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done_q <= 1'b0;
      acmd_cnt_q  <= '0;
      app_q       <= 1'b0;
      idx_q       <= '0;
      arg_q       <= '0;
      r1_q        <= FILL_BYTE;
      resp_q      <= '1;
      long_q      <= 1'b0;
      post_q      <= S_IDLE;
      blk_q       <= '0;
    end else begin
      init_done_q <= init_done_d;
      acmd_cnt_q  <= acmd_cnt_d;
      app_q       <= app_d;
      idx_q       <= idx_d;
      arg_q       <= arg_d;
      r1_q        <= r1_d;
      resp_q      <= resp_d;
      long_q      <= long_d;
      post_q      <= post_d;
      blk_q       <= blk_d;
    end
  end

  always_ff @(negedge SD_clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= 1'b1;
    end else begin
      dout_q <= tx_sr_q[3'd7 - bit_cnt_q];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_d        = tx_sr_q;
    cmd_valid_d = 1'b0;
    rd_done_d   = 1'b0;
    wr_done_d   = 1'b0;
    mem_we      = 1'b0;
    init_done_d = init_done_q;
    acmd_cnt_d  = acmd_cnt_q;
    app_d       = app_q;
    idx_d       = idx_q;
    arg_d       = arg_q;
    r1_d        = r1_q;
    resp_d      = resp_q;
    long_d      = long_q;
    post_d      = post_q;
    blk_d       = blk_q;
    idle        = ~init_done_q;
    illegal     = R1_ILLEGAL | {7'b0, idle};

    if (byte_done) begin
      tx_d = FILL_BYTE;
      case (state_q)
        S_IDLE: begin
          if (rx_byte[7:6] == 2'b01) begin
            idx_d   = rx_byte[5:0];
            state_d = S_CMD;
            cnt_d   = '0;
          end
        end
        S_CMD: begin
          if (cnt_q < 10'd4) begin
            arg_d = {arg_q[23:0], rx_byte};
            cnt_d = cnt_q + 10'd1;
          end else begin
            // Whole response is decided here; the NCR gap just replays it.
            cmd_valid_d = 1'b1;
            state_d     = S_NCR;
            cnt_d       = '0;
            app_d       = 1'b0;
            r1_d        = {7'b0, idle};
            long_d      = 1'b0;
            resp_d      = '1;
            post_d      = S_IDLE;
            blk_d       = arg_q[BW-1:0];
            case (idx_q)
              CMD0: begin
                r1_d        = R1_IDLE;
                init_done_d = 1'b0;
                acmd_cnt_d  = '0;
              end
              CMD8: begin
                long_d = 1'b1;
                resp_d = {8'h00, 8'h00, 8'h01, arg_q[7:0]};
              end
              CMD55: app_d = 1'b1;
              CMD41: begin
                if (!app_q) begin
                  r1_d = illegal;
                end else if (32'(acmd_cnt_q) < INIT_BUSY_CNT) begin
                  r1_d       = R1_IDLE;
                  acmd_cnt_d = acmd_cnt_q + 8'd1;
                end else begin
                  r1_d        = 8'h00;
                  init_done_d = 1'b1;
                end
              end
              CMD58: begin
                long_d = 1'b1;
                resp_d = OCR_VALUE;
              end
              CMD17: begin
                if (init_done_q) post_d = S_RD_TOK;
                else             r1_d   = illegal;
              end
              CMD24: begin
                if (init_done_q) post_d = S_WR_TOK;
                else             r1_d   = illegal;
              end
              default: r1_d = illegal;
            endcase
          end
        end
        S_NCR: begin
          if (cnt_q == 10'(NCR_BYTES - 1)) begin
            state_d = S_RESP;
            cnt_d   = '0;
            tx_d    = r1_q;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
        S_RESP: begin
          if (!long_q || cnt_q == 10'd4) begin
            state_d = post_q;
            cnt_d   = '0;
          end else begin
            cnt_d  = cnt_q + 10'd1;
            tx_d   = resp_q[31:24];
            resp_d = {resp_q[23:0], FILL_BYTE};
          end
        end
        S_RD_TOK: begin
          if (cnt_q == 10'(TOKEN_DELAY)) begin
            state_d = S_RD_DATA;
            cnt_d   = '0;
            tx_d    = mem_rdata;
          end else begin
            cnt_d = cnt_q + 10'd1;
            if (cnt_q == 10'(TOKEN_DELAY - 1)) tx_d = START_TOKEN;
          end
        end
        S_RD_DATA: begin
          if (cnt_q == 10'd511) begin
            state_d = S_RD_CRC;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 10'd1;
            tx_d  = mem_rdata;
          end
        end
        S_RD_CRC: begin
          if (cnt_q == 10'd1) begin
            rd_done_d = 1'b1;
            state_d   = S_IDLE;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
        S_WR_TOK: begin
          if (rx_byte == START_TOKEN) begin
            state_d = S_WR_DATA;
            cnt_d   = '0;
          end else if (rx_byte != FILL_BYTE) begin
            state_d = S_IDLE;
          end
        end
        S_WR_DATA: begin
          mem_we = 1'b1;
          if (cnt_q == 10'd511) begin
            state_d = S_WR_CRC;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
        S_WR_CRC: begin
          if (cnt_q == 10'd1) begin
            state_d = S_WR_RESP;
            cnt_d   = '0;
            tx_d    = DATA_ACCEPTED;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
        S_WR_RESP: begin
          state_d = S_WR_BUSY;
          cnt_d   = '0;
          tx_d    = BUSY_BYTE;
        end
        S_WR_BUSY: begin
          if (cnt_q == 10'(BUSY_BYTES - 1)) begin
            wr_done_d = 1'b1;
            state_d   = S_IDLE;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + 10'd1;
            tx_d  = BUSY_BYTE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Read address runs one byte ahead so the registered RAM output is ready at each byte boundary.
  always_comb begin
    rd_off   = (state_q == S_RD_DATA) ? (cnt_q[8:0] + 9'd1) : '0;
    mem_addr = (state_q == S_WR_DATA) ? {blk_q, cnt_q[8:0]} : {blk_q, rd_off};
  end

  sd_resp_mem #(
    .DEPTH(MEM_BLOCKS * 512)
  ) u_mem (
    .clk_i   (SD_clk),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (rx_byte),
    .rdata_o (mem_rdata)
  );

  assign SD_dataout = SD_cs ? 1'b1 : dout_q;
  assign init_done  = init_done_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_idx    = idx_q;
  assign cmd_arg    = arg_q;
  assign rd_done    = rd_done_q;
  assign wr_done    = wr_done_q;

endmodule

// File: tb/tb_sd_spi_responder.sv
// Host-side bench for sd_spi_responder: scripted SPI transactions against an expected-MISO scoreboard.
module tb_sd_spi_responder;

  logic        SD_clk = 1'b0;
  logic        rst_n;
  logic        SD_cs;
  logic        SD_datain;
  logic        SD_dataout;
  logic        init_done;
  logic        cmd_valid;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic        rd_done;
  logic        wr_done;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned n_cmd = 0;
  int unsigned n_rd = 0;
  int unsigned n_wr = 0;

  logic [7:0] host_q[$];
  logic [8:0] exp_q[$];

  sd_spi_responder #(
    .NCR_BYTES(1),
    .INIT_BUSY_CNT(2),
    .MEM_BLOCKS(4),
    .TOKEN_DELAY(2),
    .BUSY_BYTES(4)
  ) dut (
    .SD_clk     (SD_clk),
    .rst_n      (rst_n),
    .SD_cs      (SD_cs),
    .SD_datain  (SD_datain),
    .SD_dataout (SD_dataout),
    .init_done  (init_done),
    .cmd_valid  (cmd_valid),
    .cmd_idx    (cmd_idx),
    .cmd_arg    (cmd_arg),
    .rd_done    (rd_done),
    .wr_done    (wr_done)
  );

  always #5 SD_clk = ~SD_clk;

  always @(negedge SD_clk) begin
    if (rst_n === 1'b1) begin
      if (cmd_valid === 1'b1) n_cmd <= n_cmd + 1;
      if (rd_done === 1'b1)   n_rd  <= n_rd + 1;
      if (wr_done === 1'b1)   n_wr  <= n_wr + 1;
    end
  end

  function automatic logic [7:0] pat(input int unsigned n, input logic [7:0] key);
    return 8'(n) ^ key;
  endfunction

  task automatic push(input logic [7:0] h, input logic chk, input logic [7:0] e);
    host_q.push_back(h);
    exp_q.push_back({chk, e});
  endtask

  task automatic push_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] r1);
    push({2'b01, idx}, 1'b0, 8'h00);
    for (int i = 3; i >= 0; i--) push(arg[i*8 +: 8], 1'b0, 8'h00);
    push(8'h95, 1'b0, 8'h00);
    push(8'hFF, 1'b1, 8'hFF);
    push(8'hFF, 1'b1, r1);
  endtask

  // Starts and ends on a falling edge; MISO is sampled 1 ns after each rising edge.
  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      SD_datain = tx[i];
      @(posedge SD_clk);
      #1 rx[i] = SD_dataout;
      @(negedge SD_clk);
    end
  endtask

  task automatic run(input string tag, input bit keep_cs);
    logic [7:0] rx;
    logic [8:0] e;
    int unsigned n = 0;
    @(negedge SD_clk);
    SD_cs = 1'b0;
    while (host_q.size() > 0) begin
      xfer(host_q.pop_front(), rx);
      e = exp_q.pop_front();
      if (e[8]) begin
        checks++;
        if (rx !== e[7:0]) begin
          errors++;
          $display("FAIL %s byte %0d: got %02h expected %02h", tag, n, rx, e[7:0]);
        end
      end
      n++;
    end
    if (!keep_cs) SD_cs = 1'b1;
  endtask

  task automatic settle();
    repeat (3) @(negedge SD_clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; SD_cs = 1'b1; SD_datain = 1'b1;
    repeat (3) @(negedge SD_clk);
    #1;
    checks++;
    if (SD_dataout !== 1'b1 || init_done !== 1'b0 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs: dataout=%b init_done=%b cmd_valid=%b expected 1/0/0", SD_dataout, init_done, cmd_valid);
    end
    checks++;
    if (cmd_idx !== 6'd0 || cmd_arg !== 32'd0 || rd_done !== 1'b0 || wr_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_cmd: idx=%0d arg=%08h rd=%b wr=%b expected 0/0/0/0", cmd_idx, cmd_arg, rd_done, wr_done);
    end
    rst_n = 1'b1;
    settle();
  endtask

  task automatic test_cmd0();
    int unsigned c0 = n_cmd;
    push_cmd(6'd0, 32'h0, 8'h01);
    push(8'hFF, 1'b1, 8'hFF);
    run("cmd0", 1'b0);
    settle();
    checks++;
    if (n_cmd !== c0 + 1 || cmd_idx !== 6'd0) begin
      errors++;
      $display("FAIL cmd0_valid: pulses=%0d idx=%0d expected 1/0", n_cmd - c0, cmd_idx);
    end
    checks++;
    if (init_done !== 1'b0) begin
      errors++;
      $display("FAIL cmd0_idle: init_done=%b expected 0", init_done);
    end
  endtask

  task automatic test_illegal_idle();
    push_cmd(6'd17, 32'h1, 8'h05);
    push(8'hFF, 1'b1, 8'hFF); push(8'hFF, 1'b1, 8'hFF); push(8'hFF, 1'b1, 8'hFF);
    push_cmd(6'd41, 32'h4000_0000, 8'h05);
    push_cmd(6'd55, 32'h0, 8'h01);
    push_cmd(6'd13, 32'h0, 8'h05);
    push_cmd(6'd41, 32'h4000_0000, 8'h05);
    run("illegal_idle", 1'b0);
    settle();
  endtask

  task automatic test_cmd8();
    push_cmd(6'd8, 32'h0000_01AA, 8'h01);
    push(8'hFF, 1'b1, 8'h00); push(8'hFF, 1'b1, 8'h00);
    push(8'hFF, 1'b1, 8'h01); push(8'hFF, 1'b1, 8'hAA);
    push(8'hFF, 1'b1, 8'hFF);
    run("cmd8", 1'b0);
    settle();
    checks++;
    if (cmd_idx !== 6'd8 || cmd_arg !== 32'h0000_01AA) begin
      errors++;
      $display("FAIL cmd8_hold: idx=%0d arg=%08h expected 8/000001aa", cmd_idx, cmd_arg);
    end
  endtask

  task automatic test_acmd41();
    for (int k = 0; k < 3; k++) begin
      push_cmd(6'd55, 32'h0, 8'h01);
      push_cmd(6'd41, 32'h4000_0000, (k < 2) ? 8'h01 : 8'h00);
      run("acmd41", 1'b0);
      settle();
      checks++;
      if (init_done !== (k == 2)) begin
        errors++;
        $display("FAIL acmd41_init k=%0d: init_done=%b expected %b", k, init_done, (k == 2));
      end
    end
  endtask

  task automatic test_illegal_ready();
    push_cmd(6'd13, 32'h0, 8'h04);
    push_cmd(6'd41, 32'h4000_0000, 8'h04);
    run("illegal_ready", 1'b0);
    settle();
  endtask

  task automatic test_cmd58();
    push_cmd(6'd58, 32'h0, 8'h00);
    push(8'hFF, 1'b1, 8'hC0); push(8'hFF, 1'b1, 8'hFF);
    push(8'hFF, 1'b1, 8'h80); push(8'hFF, 1'b1, 8'h00);
    run("cmd58", 1'b0);
    settle();
  endtask

  task automatic test_write(input logic [31:0] sec, input logic [7:0] key);
    int unsigned w0 = n_wr;
    push_cmd(6'd24, sec, 8'h00);
    push(8'hFF, 1'b1, 8'hFF);
    push(8'hFE, 1'b1, 8'hFF);
    for (int unsigned i = 0; i < 512; i++) push(pat(i, key), 1'b1, 8'hFF);
    push(8'hFF, 1'b1, 8'hFF); push(8'hFF, 1'b1, 8'hFF);
    push(8'hFF, 1'b1, 8'h05);
    for (int i = 0; i < 4; i++) push(8'hFF, 1'b1, 8'h00);
    push(8'hFF, 1'b1, 8'hFF);
    run("write", 1'b0);
    settle();
    checks++;
    if (n_wr !== w0 + 1) begin
      errors++;
      $display("FAIL write_done sec=%0d: pulses=%0d expected 1", sec, n_wr - w0);
    end
  endtask

  task automatic test_read(input logic [31:0] sec, input logic [7:0] key, input int unsigned nchk);
    int unsigned r0 = n_rd;
    push_cmd(6'd17, sec, 8'h00);
    push(8'hFF, 1'b1, 8'hFF); push(8'hFF, 1'b1, 8'hFF);
    push(8'hFF, 1'b1, 8'hFE);
    for (int unsigned i = 0; i < 512; i++) push(8'hFF, (i < nchk), pat(i, key));
    push(8'hFF, 1'b1, 8'hFF); push(8'hFF, 1'b1, 8'hFF);
    push(8'hFF, 1'b1, 8'hFF);
    run("read", 1'b0);
    settle();
    checks++;
    if (n_rd !== r0 + 1) begin
      errors++;
      $display("FAIL read_done sec=%0d: pulses=%0d expected 1", sec, n_rd - r0);
    end
  endtask

  task automatic test_abort();
    int unsigned w0 = n_wr;
    push_cmd(6'd24, 32'h3, 8'h00);
    push(8'hFF, 1'b1, 8'hFF);
    push(8'hFE, 1'b1, 8'hFF);
    for (int unsigned i = 0; i < 100; i++) push(pat(i, 8'h3C), 1'b1, 8'hFF);
    run("abort", 1'b0);
    #1;
    checks++;
    if (SD_dataout !== 1'b1) begin
      errors++;
      $display("FAIL abort_miso: dataout=%b expected 1", SD_dataout);
    end
    repeat (20) @(negedge SD_clk);
    checks++;
    if (n_wr !== w0) begin
      errors++;
      $display("FAIL abort_no_done: pulses=%0d expected 0", n_wr - w0);
    end
  endtask

  task automatic test_reset_mid_read();
    int unsigned r0 = n_rd;
    push_cmd(6'd17, 32'h1, 8'h00);
    push(8'hFF, 1'b1, 8'hFF); push(8'hFF, 1'b1, 8'hFF);
    push(8'hFF, 1'b1, 8'hFE);
    for (int unsigned i = 0; i < 50; i++) push(8'hFF, 1'b1, pat(i, 8'h00));
    run("reset_mid_read", 1'b1);
    rst_n = 1'b0;
    #1;
    checks++;
    if (SD_dataout !== 1'b1 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_read: dataout=%b init_done=%b expected 1/0", SD_dataout, init_done);
    end
    @(negedge SD_clk);
    SD_cs = 1'b1;
    rst_n = 1'b1;
    repeat (20) @(negedge SD_clk);
    checks++;
    if (n_rd !== r0) begin
      errors++;
      $display("FAIL reset_no_done: pulses=%0d expected 0", n_rd - r0);
    end
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_illegal_idle();
    test_cmd8();
    test_acmd41();
    test_illegal_ready();
    test_cmd58();
    test_write(32'h1, 8'h00);
    test_write(32'h2, 8'hA5);
    test_read(32'h1, 8'h00, 512);
    test_read(32'h5, 8'h00, 512);
    test_read(32'h2, 8'hA5, 512);
    test_abort();
    test_cmd0();
    test_acmd41();
    test_read(32'h3, 8'h3C, 100);
    test_reset_mid_read();
    test_cmd0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
